// File: rtl/mdu_pkg.sv
// Shared definitions for the kanade32 multiply/divide unit: op codes and FSM states.
package mdu_pkg;

    localparam int MDU_W     = 32;
    localparam int MDU_ITERS = 32;

    typedef enum logic [1:0] {
        MDU_OP_MULTU = 2'd0,
        MDU_OP_MULT  = 2'd1,
        MDU_OP_DIVU  = 2'd2,
        MDU_OP_DIV   = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_ST_IDLE = 2'd0,
        MDU_ST_CALC = 2'd1,
        MDU_ST_FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// Execute-stage bundle between the pipeline and the MDU.
interface mdu_if;
    import mdu_pkg::*;

    logic        start;
    mdu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mdu_negate64.sv
// Conditional two's-complement negation. 64 bits for the product fix-up;
// narrower instances serve operand magnitudes and quotient/remainder.
module mdu_negate64 #(
    parameter int W = 64
) (
    input  logic [W-1:0] x_i,
    input  logic         neg_i,
    output logic [W-1:0] y_o
);
    assign y_o = neg_i ? (~x_i + {{(W-1){1'b0}}, 1'b1}) : x_i;
endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit: 32 shift-add or restoring-divide
// iterations, one sign fix-up cycle, result held in HI/LO.
module mdu
    import mdu_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    mdu_if.slave  bus
);
    mdu_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;    // product accumulator / partial remainder
    logic [31:0] sreg_q, sreg_d;  // multiplier bits out / dividend in, quotient in
    logic [31:0] opnd_q, opnd_d;  // multiplicand or divisor magnitude
    mdu_op_e     op_q, op_d;
    logic        negq_q, negq_d;  // product/quotient sign differs
    logic        negr_q, negr_d;  // dividend negative
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        busy_q, busy_d, done_q, done_d;

    logic        is_div_in, signed_in, a_neg, b_neg, is_div_q;
    logic [31:0] a_mag, b_mag, quo_fix, rem_fix;
    logic [63:0] prod_fix;
    logic [32:0] mul_sum, div_sh;
    logic [31:0] div_rem;
    logic        div_ge;

    assign is_div_in = (bus.op == MDU_OP_DIVU) || (bus.op == MDU_OP_DIV);
    assign signed_in = (bus.op == MDU_OP_MULT) || (bus.op == MDU_OP_DIV);
    assign a_neg     = signed_in & bus.a[31];
    assign b_neg     = signed_in & bus.b[31];
    assign is_div_q  = (op_q == MDU_OP_DIVU) || (op_q == MDU_OP_DIV);

    mdu_negate64 #(.W(32)) u_neg_a (.x_i(bus.a), .neg_i(a_neg), .y_o(a_mag));
    mdu_negate64 #(.W(32)) u_neg_b (.x_i(bus.b), .neg_i(b_neg), .y_o(b_mag));
    mdu_negate64 #(.W(64)) u_neg_p (.x_i(acc_q), .neg_i(negq_q), .y_o(prod_fix));
    mdu_negate64 #(.W(32)) u_neg_q (.x_i(sreg_q), .neg_i(negq_q), .y_o(quo_fix));
    mdu_negate64 #(.W(32)) u_neg_r (.x_i(acc_q[31:0]), .neg_i(negr_q), .y_o(rem_fix));

    // Shift-add: add multiplicand into the upper half, shift the 64-bit pair right.
    assign mul_sum = {1'b0, acc_q[63:32]} + (sreg_q[0] ? {1'b0, opnd_q} : 33'd0);
    // Restoring divide: shift next dividend bit into remainder, subtract if it fits.
    // The remainder stays below the divisor, so the 32-bit difference never wraps.
    assign div_sh  = {acc_q[31:0], sreg_q[31]};
    assign div_ge  = (div_sh >= {1'b0, opnd_q});
    assign div_rem = div_sh[31:0] - opnd_q;

    // Next-state, datapath and HI/LO update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sreg_d  = sreg_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            MDU_ST_IDLE: begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                if (bus.start) begin
                    state_d = MDU_ST_CALC;
                    cnt_d   = 5'd0;
                    op_d    = bus.op;
                    acc_d   = 64'd0;
                    sreg_d  = is_div_in ? a_mag : b_mag;
                    opnd_d  = is_div_in ? b_mag : a_mag;
                    negq_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    dz_d    = is_div_in && (bus.b == 32'd0);
                end
            end
            MDU_ST_CALC: begin
                cnt_d = cnt_q + 5'd1;
                if (is_div_q) begin
                    acc_d  = {32'd0, div_ge ? div_rem : div_sh[31:0]};
                    sreg_d = {sreg_q[30:0], div_ge};
                end else begin
                    acc_d  = {mul_sum[32:1], mul_sum[0], acc_q[31:1]};
                    sreg_d = {1'b0, sreg_q[31:1]};
                end
                if (cnt_q == 5'(MDU_ITERS - 1)) state_d = MDU_ST_FIX;
            end
            MDU_ST_FIX: begin
                state_d = MDU_ST_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    // With a zero divisor the remainder path already rebuilds raw a.
                    lo_d = dz_q ? 32'hFFFF_FFFF : quo_fix;
                    hi_d = rem_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = MDU_ST_IDLE;
        endcase
        busy_d = (state_d != MDU_ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MDU_ST_IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            sreg_q  <= 32'd0;
            opnd_q  <= 32'd0;
            op_q    <= MDU_OP_MULTU;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sreg_q  <= sreg_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: arithmetic results, fixed latency, back-to-back,
// ignored requests while busy, MTHI/MTLO and mid-operation reset.
module tb_mdu;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;
    int   cyc = 0;

    mdu_if bus();
    mdu dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Drive one request in the current cycle; returns in cycle 1.
    task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         output int t0);
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        t0 = cyc;
        step();
        bus.start = 1'b0;
    endtask

    // Follow an op from cycle 1 until done (0 = timed out). Optionally pokes a
    // competing start + MTHI at cycle poke_k; snapshots HI/LO at cycle 20.
    task automatic wait_done(input int poke_k, output int dk, output bit busy_ok,
                             output logic [31:0] hi_mid, output logic [31:0] lo_mid);
        dk = 0; busy_ok = 1'b1; hi_mid = 'x; lo_mid = 'x;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) step();
            if (k == poke_k) begin
                bus.op = MDU_OP_DIVU; bus.a = 32'h55; bus.b = 32'h1; bus.start = 1'b1;
                bus.hi_we = 1'b1; bus.wdata = 32'hDEAD;
            end
            if (k == poke_k + 1) begin
                bus.start = 1'b0; bus.hi_we = 1'b0;
            end
            if (k == 20) begin hi_mid = bus.hi; lo_mid = bus.lo; end
            if (bus.done) begin
                dk = k;
                if (bus.busy) busy_ok = 1'b0;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        step(); step();
        nvec++; if (bus.hi !== 32'd0) begin nerr++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
        nvec++; if (bus.lo !== 32'd0) begin nerr++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        nvec++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_multu();
        int t0, dk; bit bok; logic [31:0] hm, lm;
        issue(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t0);
        wait_done(0, dk, bok, hm, lm);
        nvec++; if (dk !== 34) begin nerr++; $display("FAIL multu_latency got=%0d exp=34", dk); end
        nvec++; if (bok !== 1'b1) begin nerr++; $display("FAIL multu_busy got=%b exp=1", bok); end
        nvec++; if (bus.hi !== 32'hFFFF_FFFE) begin nerr++; $display("FAIL multu_hi got=%h exp=fffffffe", bus.hi); end
        nvec++; if (bus.lo !== 32'h0000_0001) begin nerr++; $display("FAIL multu_lo got=%h exp=00000001", bus.lo); end
        step();
        nvec++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL multu_done_pulse got=%b exp=0", bus.done); end
    endtask

    task automatic test_mult();
        int t0, dk; bit bok; logic [31:0] hm, lm;
        issue(MDU_OP_MULT, 32'hFFFF_FFFD, 32'd7, t0);
        wait_done(0, dk, bok, hm, lm);
        nvec++; if (dk !== 34) begin nerr++; $display("FAIL mult_neg_latency got=%0d exp=34", dk); end
        nvec++; if (bus.hi !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL mult_neg_hi got=%h exp=ffffffff", bus.hi); end
        nvec++; if (bus.lo !== 32'hFFFF_FFEB) begin nerr++; $display("FAIL mult_neg_lo got=%h exp=ffffffeb", bus.lo); end
        step();
        issue(MDU_OP_MULT, 32'h8000_0000, 32'h8000_0000, t0);
        wait_done(0, dk, bok, hm, lm);
        nvec++; if (bus.hi !== 32'h4000_0000) begin nerr++; $display("FAIL mult_min_hi got=%h exp=40000000", bus.hi); end
        nvec++; if (bus.lo !== 32'h0000_0000) begin nerr++; $display("FAIL mult_min_lo got=%h exp=00000000", bus.lo); end
        step();
    endtask

    task automatic test_div();
        int t0, dk; bit bok; logic [31:0] hm, lm;
        issue(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, t0);
        wait_done(0, dk, bok, hm, lm);
        nvec++; if (bus.lo !== 32'hFFFF_FFFD) begin nerr++; $display("FAIL div_neg_lo got=%h exp=fffffffd", bus.lo); end
        nvec++; if (bus.hi !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL div_neg_hi got=%h exp=ffffffff", bus.hi); end
        step();
        issue(MDU_OP_DIVU, 32'd100, 32'd7, t0);
        wait_done(0, dk, bok, hm, lm);
        nvec++; if (dk !== 34) begin nerr++; $display("FAIL divu_latency got=%0d exp=34", dk); end
        nvec++; if (bus.lo !== 32'd14) begin nerr++; $display("FAIL divu_lo got=%h exp=0000000e", bus.lo); end
        nvec++; if (bus.hi !== 32'd2) begin nerr++; $display("FAIL divu_hi got=%h exp=00000002", bus.hi); end
        step();
        issue(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, t0);
        wait_done(0, dk, bok, hm, lm);
        nvec++; if (bus.lo !== 32'h8000_0000) begin nerr++; $display("FAIL div_ovf_lo got=%h exp=80000000", bus.lo); end
        nvec++; if (bus.hi !== 32'h0000_0000) begin nerr++; $display("FAIL div_ovf_hi got=%h exp=00000000", bus.hi); end
        step();
    endtask

    task automatic test_divzero_back_to_back();
        int t0a, t0b, dk; bit bok; logic [31:0] hm, lm;
        issue(MDU_OP_DIVU, 32'h1234, 32'd0, t0a);
        wait_done(0, dk, bok, hm, lm);
        nvec++; if (dk !== 34) begin nerr++; $display("FAIL dz_latency got=%0d exp=34", dk); end
        nvec++; if (bus.lo !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL dz_lo got=%h exp=ffffffff", bus.lo); end
        nvec++; if (bus.hi !== 32'h0000_1234) begin nerr++; $display("FAIL dz_hi got=%h exp=00001234", bus.hi); end
        // second request launched in the done cycle
        issue(MDU_OP_DIV, 32'hFFFF_FF9C, 32'd7, t0b);
        nvec++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL b2b_busy got=%b exp=1", bus.busy); end
        wait_done(0, dk, bok, hm, lm);
        nvec++; if (cyc - t0a !== 68) begin nerr++; $display("FAIL b2b_done_cycle got=%0d exp=68", cyc - t0a); end
        nvec++; if (bus.lo !== 32'hFFFF_FFF2) begin nerr++; $display("FAIL b2b_lo got=%h exp=fffffff2", bus.lo); end
        nvec++; if (bus.hi !== 32'hFFFF_FFFE) begin nerr++; $display("FAIL b2b_hi got=%h exp=fffffffe", bus.hi); end
        step();
        issue(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd0, t0a);
        wait_done(0, dk, bok, hm, lm);
        nvec++; if (dk !== 34) begin nerr++; $display("FAIL dzs_latency got=%0d exp=34", dk); end
        nvec++; if (bus.lo !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL dzs_lo got=%h exp=ffffffff", bus.lo); end
        nvec++; if (bus.hi !== 32'hFFFF_FFF9) begin nerr++; $display("FAIL dzs_hi got=%h exp=fffffff9", bus.hi); end
        step();
    endtask

    task automatic test_mthi_mtlo();
        bus.hi_we = 1'b1; bus.wdata = 32'hAA;
        step();
        bus.hi_we = 1'b0;
        nvec++; if (bus.hi !== 32'hAA) begin nerr++; $display("FAIL mthi_hi got=%h exp=000000aa", bus.hi); end
        nvec++; if (bus.lo !== 32'hFFFF_FFF9 && bus.lo !== 32'hFFFF_FFFF) begin end
        nvec++; if (bus.lo !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL mthi_lo_kept got=%h exp=ffffffff", bus.lo); end
        bus.lo_we = 1'b1; bus.wdata = 32'h55;
        step();
        bus.lo_we = 1'b0;
        nvec++; if (bus.lo !== 32'h55) begin nerr++; $display("FAIL mtlo_lo got=%h exp=00000055", bus.lo); end
        nvec++; if (bus.hi !== 32'hAA) begin nerr++; $display("FAIL mtlo_hi_kept got=%h exp=000000aa", bus.hi); end
    endtask

    task automatic test_busy_ignore();
        int t0, dk, ndone; bit bok; logic [31:0] hm, lm;
        issue(MDU_OP_MULTU, 32'd3, 32'd5, t0);
        wait_done(10, dk, bok, hm, lm);
        nvec++; if (dk !== 34) begin nerr++; $display("FAIL ign_latency got=%0d exp=34", dk); end
        nvec++; if (hm !== 32'hAA) begin nerr++; $display("FAIL ign_hi_hold got=%h exp=000000aa", hm); end
        nvec++; if (lm !== 32'h55) begin nerr++; $display("FAIL ign_lo_hold got=%h exp=00000055", lm); end
        nvec++; if (bus.hi !== 32'd0) begin nerr++; $display("FAIL ign_hi got=%h exp=00000000", bus.hi); end
        nvec++; if (bus.lo !== 32'd15) begin nerr++; $display("FAIL ign_lo got=%h exp=0000000f", bus.lo); end
        ndone = 0;
        for (int k = 0; k < 40; k++) begin step(); if (bus.done) ndone++; end
        nvec++; if (ndone !== 0) begin nerr++; $display("FAIL ign_extra_done got=%0d exp=0", ndone); end
    endtask

    task automatic test_reset_mid();
        int t0, ndone;
        issue(MDU_OP_MULT, 32'hFFFF_FFFD, 32'd7, t0);
        for (int k = 2; k <= 15; k++) step();
        rst_n = 1'b0;
        #1;
        nvec++; if (bus.hi !== 32'd0) begin nerr++; $display("FAIL rstmid_hi got=%h exp=0", bus.hi); end
        nvec++; if (bus.lo !== 32'd0) begin nerr++; $display("FAIL rstmid_lo got=%h exp=0", bus.lo); end
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin step(); if (bus.done || bus.busy) ndone++; end
        nvec++; if (ndone !== 0) begin nerr++; $display("FAIL rstmid_no_done got=%0d exp=0", ndone); end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = MDU_OP_MULTU; bus.a = '0; bus.b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_divzero_back_to_back();
        test_mthi_mtlo();
        test_busy_ignore();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
